// File: rtl/port_tx_gen.sv
// Ingress transmitter for one switch port: queues source-stamped packet requests and injects them
// only while the switch ingress FIFO reports room, with an optional forced idle gap per packet.
module port_tx_gen #(
  parameter int unsigned PORT_ID    = 0,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MIN_GAP    = 0,
  parameter int unsigned ALLOW_SELF = 0,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_target,
  input  logic [1:0]           req_type,
  input  logic [7:0]           req_data,
  input  logic                 sw_fifo_full,
  output logic                 valid_out,
  output logic [3:0]           source_out,
  output logic [3:0]           target_out,
  output logic [1:0]           type_out,
  output logic [7:0]           data_out,
  output logic [CNT_WIDTH-1:0] sent_cnt,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt
);

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [3:0]  SelfMask  = 4'(1 << PORT_ID);
  localparam logic [3:0]  GapLoad   = 4'(MIN_GAP) - 4'd1;

  typedef enum logic [1:0] {StIdle, StHold, StSend, StGap} state_e;

  state_e state_q, state_d;
  logic [3:0]  gap_q, gap_d;
  logic        init_q;

  // Queue entry layout: {target, type, data}
  logic [13:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count;
  logic        q_full, q_empty;

  logic        hs, legal, push, pop;
  logic [AW:0] head_idx;
  logic [13:0] head;

  logic        valid_d;
  logic [3:0]  source_d, target_d;
  logic [1:0]  type_d;
  logic [7:0]  data_d;

  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;

  // init_q holds req_ready low for the first cycle after reset is released.
  assign req_ready = !q_full && !init_q;
  assign hs        = req_valid && req_ready;
  assign legal     = (|req_target) && ((ALLOW_SELF != 0) || !(|(req_target & SelfMask)));
  assign push      = hs && legal;
  assign pop       = (state_q == StSend);

  // Entry that will sit at the head once this cycle's pop has taken effect.
  assign head_idx  = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  assign head      = mem_q[head_idx[AW-1:0]];

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    unique case (state_q)
      StIdle: begin
        if (!q_empty) state_d = sw_fifo_full ? StHold : StSend;
      end
      StHold: begin
        if (!sw_fifo_full) state_d = StSend;
      end
      StSend: begin
        if (MIN_GAP > 0) begin
          state_d = StGap;
          gap_d   = GapLoad;
        end else if (count > (AW+1)'(1)) begin
          // Entries pushed this same cycle are not counted; they go out via IDLE.
          state_d = sw_fifo_full ? StHold : StSend;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (!q_empty) begin
          state_d = sw_fifo_full ? StHold : StSend;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d  = 1'b0;
    source_d = 4'd0;
    target_d = 4'd0;
    type_d   = 2'd0;
    data_d   = 8'd0;
    if (state_d == StSend) begin
      valid_d  = 1'b1;
      source_d = SelfMask;
      target_d = head[13:10];
      type_d   = head[9:8];
      data_d   = head[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {req_target, req_type, req_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gap_q      <= 4'd0;
      init_q     <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      valid_out  <= 1'b0;
      source_out <= 4'd0;
      target_out <= 4'd0;
      type_out   <= 2'd0;
      data_out   <= 8'd0;
      sent_cnt   <= '0;
      stall_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      init_q     <= 1'b0;
      valid_out  <= valid_d;
      source_out <= source_d;
      target_out <= target_d;
      type_out   <= type_d;
      data_out   <= data_d;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      // Statistics saturate rather than wrap.
      if (pop && sent_cnt != '1) sent_cnt <= sent_cnt + 1'b1;
      if (state_q == StHold && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (hs && !legal && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_port_tx_gen.sv
// Directed bench for port_tx_gen: cycle table for basic/illegal/back-to-back traffic plus
// hand sequences for backpressure, MIN_GAP spacing, counter saturation and mid-traffic reset.
module tb_port_tx_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, sw_fifo_full;
  logic [3:0]  req_target;
  logic [1:0]  req_type;
  logic [7:0]  req_data;
  logic        valid_out;
  logic [3:0]  source_out, target_out;
  logic [1:0]  type_out;
  logic [7:0]  data_out;
  logic [15:0] sent_cnt, stall_cnt, err_cnt;

  logic        g_valid, g_ready;
  logic [3:0]  g_tgt;
  logic [1:0]  g_typ;
  logic [7:0]  g_data;
  logic        g_vout;
  logic [3:0]  g_src, g_tout;
  logic [1:0]  g_typout;
  logic [7:0]  g_dout;
  logic [1:0]  g_sent, g_stall, g_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  port_tx_gen #(.PORT_ID(0), .DEPTH(4), .MIN_GAP(0), .ALLOW_SELF(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_type(req_type), .req_data(req_data),
    .sw_fifo_full(sw_fifo_full), .valid_out(valid_out), .source_out(source_out),
    .target_out(target_out), .type_out(type_out), .data_out(data_out),
    .sent_cnt(sent_cnt), .stall_cnt(stall_cnt), .err_cnt(err_cnt)
  );

  port_tx_gen #(.PORT_ID(2), .DEPTH(4), .MIN_GAP(3), .ALLOW_SELF(1), .CNT_WIDTH(2)) dut_gap (
    .clk(clk), .rst(rst), .req_valid(g_valid), .req_ready(g_ready),
    .req_target(g_tgt), .req_type(g_typ), .req_data(g_data),
    .sw_fifo_full(1'b0), .valid_out(g_vout), .source_out(g_src),
    .target_out(g_tout), .type_out(g_typout), .data_out(g_dout),
    .sent_cnt(g_sent), .stall_cnt(g_stall), .err_cnt(g_err)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  tgt;
    logic [1:0]  typ;
    logic [7:0]  data;
    logic        e_ready;
    logic        e_valid;
    logic [3:0]  e_src;
    logic [3:0]  e_tgt;
    logic [1:0]  e_typ;
    logic [7:0]  e_data;
    logic [15:0] e_sent;
    logic [15:0] e_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  initial begin
    int          n;
    int          idx [8];
    logic [7:0]  dat [8];
    logic [3:0]  src [8];
    logic [15:0] prev;
    logic [63:0] act, exp;

    // Inputs for the cycle, then outputs expected in that same cycle.
    vecs[0]  = '{1'b1, 4'b0100, 2'd2, 8'hA5, 1'b0, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd0, 16'd0};
    vecs[1]  = '{1'b1, 4'b0100, 2'd2, 8'hA5, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd0, 16'd0};
    vecs[2]  = '{1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd0, 16'd0};
    vecs[3]  = '{1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b1, 4'h1, 4'b0100, 2'd2, 8'hA5, 16'd0, 16'd0};
    vecs[4]  = '{1'b1, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd1, 16'd0};
    vecs[5]  = '{1'b1, 4'b0001, 2'd1, 8'h3C, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd1, 16'd1};
    vecs[6]  = '{1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd1, 16'd2};
    vecs[7]  = '{1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd1, 16'd2};
    vecs[8]  = '{1'b1, 4'b1010, 2'd1, 8'h11, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd1, 16'd2};
    vecs[9]  = '{1'b1, 4'b0110, 2'd3, 8'h22, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd1, 16'd2};
    vecs[10] = '{1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b1, 4'h1, 4'b1010, 2'd1, 8'h11, 16'd1, 16'd2};
    vecs[11] = '{1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b1, 4'h1, 4'b0110, 2'd3, 8'h22, 16'd2, 16'd2};
    vecs[12] = '{1'b0, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0,    2'd0, 8'h00, 16'd3, 16'd2};

    rst = 1'b1; req_valid = 1'b0; req_target = '0; req_type = '0; req_data = '0;
    sw_fifo_full = 1'b0; g_valid = 1'b0; g_tgt = '0; g_typ = '0; g_data = '0;
    repeat (3) @(negedge clk);
    check("reset_state", {44'd0, req_ready, valid_out, source_out, target_out, type_out,
                          data_out, stall_cnt},
          64'd0);

    // Single send, illegal requests, back-to-back pair.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      req_valid  = vecs[i].valid;
      req_target = vecs[i].tgt;
      req_type   = vecs[i].typ;
      req_data   = vecs[i].data;
      #1;
      act = {12'd0, req_ready, valid_out, source_out, target_out, type_out, data_out,
             sent_cnt, err_cnt};
      exp = {12'd0, vecs[i].e_ready, vecs[i].e_valid, vecs[i].e_src, vecs[i].e_tgt,
             vecs[i].e_typ, vecs[i].e_data, vecs[i].e_sent, vecs[i].e_err};
      check($sformatf("vec%0d", i), act, exp);
    end

    // Backpressure: fill the queue while the switch is full.
    sw_fifo_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_target = 4'b0010; req_type = 2'(k); req_data = 8'h40 + 8'(k);
      #1;
      check($sformatf("fill_ready%0d", k), {63'd0, req_ready}, 64'd1);
    end
    @(negedge clk);
    req_data = 8'h44;
    #1;
    check("full_ready_low", {62'd0, req_ready, valid_out}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      prev = stall_cnt;
      @(negedge clk);
      #1;
      check($sformatf("stall_inc%0d", k), {46'd0, valid_out, req_ready, stall_cnt},
            {48'd0, prev + 16'd1});
    end
    @(negedge clk);
    req_valid = 1'b0; sw_fifo_full = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (valid_out && n < 8) begin
        idx[n] = i; dat[n] = data_out; n++;
      end
    end
    check("b2b_count", 64'(n), 64'd4);
    for (int j = 0; j < 4 && j < n; j++) begin
      check($sformatf("b2b_pkt%0d", j), {48'd0, 8'(idx[j]), dat[j]}, {48'd0, 8'(j), 8'h40 + 8'(j)});
    end
    check("sent_after_b2b", {48'd0, sent_cnt}, 64'd7);

    // MIN_GAP=3 spacing, order, own-port target allowed, 2-bit counter saturation.
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      g_valid = (c < 5);
      g_tgt   = 4'b0100;
      g_typ   = 2'(c);
      g_data  = 8'hC0 + 8'(c);
      #1;
      if (c < 5) check($sformatf("gap_ready%0d", c), {63'd0, g_ready}, 64'd1);
      if (g_vout && n < 8) begin
        idx[n] = c; dat[n] = g_dout; src[n] = g_src; n++;
      end
    end
    g_valid = 1'b0;
    check("gap_count", 64'(n), 64'd5);
    for (int j = 0; j < 5 && j < n; j++) begin
      check($sformatf("gap_pkt%0d", j), {44'd0, src[j], 8'(idx[j]), dat[j]},
            {44'd0, 4'b0100, 8'(2 + 4 * j), 8'hC0 + 8'(j)});
    end
    check("gap_sent_sat", {60'd0, g_sent, g_err}, {60'd0, 2'd3, 2'd0});

    // Reset with packets queued while holding.
    sw_fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_target = 4'b1000; req_type = 2'd1; req_data = 8'h70 + 8'(k);
    end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("hold_before_rst", {63'd0, stall_cnt > 16'd4}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_clears", {13'd0, req_ready, valid_out, sent_cnt, stall_cnt, err_cnt}, 64'd0);
    rst = 1'b0; sw_fifo_full = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (valid_out) n++;
    end
    check("no_stale_pkt", {31'd0, sent_cnt, 16'(n)}, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
